// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider, 800x525 raster counters, registered
// blank-forced colour and active-low syncs, plus a once-per-frame tick.
// Optional build macro VGA_TEST_PATTERN_EN replaces rgb_in with 8 colour bars.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_DISP_START = 144,
  parameter int unsigned H_DISP_END   = 784,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_DISP_START = 35,
  parameter int unsigned V_DISP_END   = 515
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_tick,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int unsigned   DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_SW    = 10'(H_SYNC);
  localparam logic [9:0]    V_SW    = 10'(V_SYNC);
  localparam logic [9:0]    H_DS    = 10'(H_DISP_START);
  localparam logic [9:0]    H_DE    = 10'(H_DISP_END);
  localparam logic [9:0]    V_DS    = 10'(V_DISP_START);
  localparam logic [9:0]    V_DE    = 10'(V_DISP_END);

  logic [DW-1:0] r_div;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          r_hs;
  logic          r_vs;
  logic [11:0]   r_rgb;
  logic          w_tick;
  logic          w_hwrap;
  logic          w_vwrap;
  logic          w_bright;
  logic [11:0]   w_col;

  // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_div <= '0;
    else if (r_div == DIV_MAX) r_div <= '0;
    else                      r_div <= r_div + 1'b1;
  end

  // Tick is gated by rst so it reads 0 in reset even when CLK_DIV=1
  assign w_tick   = ~rst & (r_div == DIV_MAX);
  assign w_hwrap  = (r_h == H_MAX);
  assign w_vwrap  = (r_v == V_MAX);
  assign w_bright = (r_h >= H_DS) && (r_h < H_DE) && (r_v >= V_DS) && (r_v < V_DE);

  // Raster counters advance once per pixel tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_hwrap) begin
        r_h <= '0;
        r_v <= w_vwrap ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_DISP_END - H_DISP_START) / 8;
  logic [9:0] w_hoff;
  logic [2:0] w_bar;

  // Colour-bar generator: bar index from offset into the visible line
  always_comb begin
    w_hoff = r_h - H_DS;
    w_bar  = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (w_hoff >= 10'(k * BAR_W)) w_bar = 3'(k);
    end
    case (w_bar)
      3'd0:    w_col = 12'hFFF;
      3'd1:    w_col = 12'hFF0;
      3'd2:    w_col = 12'h0FF;
      3'd3:    w_col = 12'h0F0;
      3'd4:    w_col = 12'hF0F;
      3'd5:    w_col = 12'hF00;
      3'd6:    w_col = 12'h00F;
      default: w_col = 12'h000;
    endcase
  end
`else
  assign w_col = rgb_in;
`endif

  // Output stage: syncs and colour register the current pixel on each tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_rgb <= '0;
    end else if (w_tick) begin
      r_hs  <= ~(r_h < H_SW);
      r_vs  <= ~(r_v < V_SW);
      r_rgb <= w_bright ? w_col : '0;
    end
  end

  assign hCount     = r_h;
  assign vCount     = r_v;
  assign bright     = w_bright;
  assign pix_tick   = w_tick;
  assign frame_tick = w_tick & w_hwrap & w_vwrap;
  assign hsync      = r_hs;
  assign vsync      = r_vs;
  assign vga_r      = r_rgb[11:8];
  assign vga_g      = r_rgb[7:4];
  assign vga_b      = r_rgb[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a shrunken raster (22x8, CLK_DIV=2)
// so whole frames fit in a few hundred clocks.
module tb_vga_timing_gen;

  localparam int CD  = 2;
  localparam int HT  = 22;
  localparam int HS  = 2;
  localparam int HDS = 3;
  localparam int HDE = 19;
  localparam int VT  = 8;
  localparam int VS  = 2;
  localparam int VDS = 2;
  localparam int VDE = 7;
  localparam int FR  = HT * VT * CD;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rgb_in;
  logic [9:0]  hCount, vCount;
  logic        bright, pix_tick, frame_tick, hsync, vsync;
  logic [3:0]  vga_r, vga_g, vga_b;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_DISP_START(HDS), .H_DISP_END(HDE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_DISP_START(VDS), .V_DISP_END(VDE)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .hCount(hCount), .vCount(vCount),
    .bright(bright), .pix_tick(pix_tick), .frame_tick(frame_tick),
    .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_div, m_h, m_v;
  logic m_hs, m_vs, m_tick, m_bright, m_ft;
  logic [11:0] m_col;

  int cyc, n_ft, ft_first, ft_second, hs_low, vs_low, first_col;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] expcol(input logic [11:0] d, input int h);
`ifdef VGA_TEST_PATTERN_EN
    case ((h - HDS) / ((HDE - HDS) / 8))
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
`else
    return (h >= 0) ? d : d;
`endif
  endfunction

  task automatic model_comb();
    m_tick   = (m_div == CD - 1);
    m_bright = (m_h >= HDS) && (m_h < HDE) && (m_v >= VDS) && (m_v < VDE);
    m_ft     = m_tick && (m_h == HT - 1) && (m_v == VT - 1);
  endtask

  task automatic model_reset();
    m_div = 0; m_h = 0; m_v = 0;
    m_hs = 1'b1; m_vs = 1'b1; m_col = '0;
    model_comb();
    cyc = 0; n_ft = 0; ft_first = -1; ft_second = -1;
    hs_low = 0; vs_low = 0; first_col = -1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hCount"}, hCount, 0);
    chk({tag, "_vCount"}, vCount, 0);
    chk({tag, "_bright"}, bright, 0);
    chk({tag, "_pix_tick"}, pix_tick, 0);
    chk({tag, "_frame_tick"}, frame_tick, 0);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
  endtask

  // One clock: drive rgb_in (random off-tick), advance the model, compare all outputs
  task automatic step();
    logic [11:0] drv;
    drv = m_tick ? 12'hF0F : 12'($urandom);
    rgb_in = drv;
    @(posedge clk); #1;
    cyc++;
    if (m_tick) begin
      m_hs  = !(m_h < HS);
      m_vs  = !(m_v < VS);
      m_col = m_bright ? expcol(drv, m_h) : 12'h000;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end
    m_div = (m_div == CD - 1) ? 0 : m_div + 1;
    model_comb();
    chk("hCount", hCount, m_h);
    chk("vCount", vCount, m_v);
    chk("bright", bright, m_bright);
    chk("pix_tick", pix_tick, m_tick);
    chk("frame_tick", frame_tick, m_ft);
    chk("hsync", hsync, m_hs);
    chk("vsync", vsync, m_vs);
    chk("rgb", {vga_r, vga_g, vga_b}, m_col);
    if (frame_tick) begin
      if (n_ft == 0) ft_first = cyc;
      else if (n_ft == 1) ft_second = cyc;
      n_ft++;
    end
    if (cyc > FR && cyc <= 2 * FR) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
    end
    if (first_col < 0 && {vga_r, vga_g, vga_b} != 12'h000) first_col = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst = 1'b1;
    rgb_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");

    // Release and check divider start-up
    rst = 1'b0;
    model_reset();
    chk("pre_tick", pix_tick, 0);
    step();
    chk("first_tick", pix_tick, 1);
    chk("first_tick_h", hCount, 0);
    chk("first_tick_hsync", hsync, 1);
    step();
    chk("after_tick_h", hCount, 1);
    chk("after_tick_hsync", hsync, 0);
    chk("after_tick_pix", pix_tick, 0);

    // Two full frames plus margin
    repeat (2 * FR + 10) step();
    chk("ft_first", ft_first, FR - 1);
    chk("ft_period", ft_second - ft_first, FR);
    chk("hsync_low_clks", hs_low, HS * CD * VT);
    chk("vsync_low_clks", vs_low, VS * HT * CD);
    chk("first_colour_clk", first_col, CD * (VDS * HT + HDS + 1));

    // Walk to (10,4) and reset mid-frame
    found = 1'b0;
    for (int i = 0; i < FR + 4 && !found; i++) begin
      if (m_h == 10 && m_v == 4) found = 1'b1;
      else step();
    end
    chk("midframe_reach", found, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset("async");
    repeat (3) @(posedge clk);
    #1;
    check_reset("held");
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < FR + 4 && n_ft == 0; i++) step();
    chk("post_reset_ft", ft_first, FR - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
